// File: rtl/md5_crack_pkg.sv
// Shared definitions for the MD5 cracking front end: field widths, dispatcher
// state encoding and small state-classification helpers.
package md5_crack_pkg;

    localparam int HASH_W     = 128;
    localparam int CHAR_W     = 8;
    localparam int INC_W      = 3;
    localparam int LANE_IDX_W = 3;
    localparam int CNT_W      = 32;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD      = 3'd1,
        ST_RUN       = 3'd2,
        ST_FOUND     = 3'd3,
        ST_NOT_FOUND = 3'd4,
        ST_TIMEOUT   = 3'd5
    } state_t;

    // A job has finished and its result is being held.
    function automatic logic is_terminal(input state_t s);
        return (s == ST_FOUND) || (s == ST_NOT_FOUND) || (s == ST_TIMEOUT);
    endfunction

    // States in which a new job may be launched.
    function automatic logic accepts_start(input state_t s);
        return (s == ST_IDLE) || is_terminal(s);
    endfunction

endpackage

// File: rtl/md5_hit_arbiter.sv
// Lowest-index priority encoder over the lane hit flags, plus the matching
// plaintext mux. Purely combinational; the dispatcher registers the result.
module md5_hit_arbiter
    import md5_crack_pkg::*;
#(
    parameter int NUM_WORKERS = 2
) (
    input  logic [NUM_WORKERS-1:0]        hit,
    input  logic [HASH_W*NUM_WORKERS-1:0] plaintext_in,
    output logic                          any_hit,
    output logic [LANE_IDX_W-1:0]         lane,
    output logic [HASH_W-1:0]             plaintext
);

    logic [HASH_W-1:0] lane_pt [NUM_WORKERS];

    // Unpack the flat plaintext bus into one word per lane.
    for (genvar gi = 0; gi < NUM_WORKERS; gi++) begin : g_unpack
        assign lane_pt[gi] = plaintext_in[gi*HASH_W +: HASH_W];
    end

    // Scan from the top lane down so the lowest set index is the last to win.
    always_comb begin
        any_hit   = |hit;
        lane      = '0;
        plaintext = '0;
        for (int i = NUM_WORKERS - 1; i >= 0; i--) begin
            if (hit[i]) begin
                lane      = LANE_IDX_W'(i);
                plaintext = lane_pt[i];
            end
        end
    end

endmodule

// File: rtl/md5_job_dispatcher.sv
// MD5 job dispatcher: splits the keyspace across NUM_WORKERS lanes, holds the
// lanes in reset for RESET_CYCLES, runs them, and collects the first hit.
// Optional feature macro: DISPATCH_TIMEOUT_EN adds a RUN-cycle budget
// (TIMEOUT_CYCLES) and the TIMEOUT state; without it timed_out is tied low.
module md5_job_dispatcher
    import md5_crack_pkg::*;
#(
    parameter int NUM_WORKERS  = 2,
    parameter int RESET_CYCLES = 4
`ifdef DISPATCH_TIMEOUT_EN
    ,
    parameter logic [CNT_W-1:0] TIMEOUT_CYCLES = 32'hFFFF
`endif
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic                          clear,
    input  logic [HASH_W-1:0]             target_hash_in,
    input  logic [CHAR_W-1:0]             charset_start,
    output logic                          worker_reset,
    output logic [HASH_W-1:0]             worker_target_hash,
    output logic [CHAR_W*NUM_WORKERS-1:0] worker_start_pos,
    output logic [INC_W*NUM_WORKERS-1:0]  worker_increment,
    input  logic [NUM_WORKERS-1:0]        worker_busy,
    input  logic [NUM_WORKERS-1:0]        worker_hit,
    input  logic [HASH_W*NUM_WORKERS-1:0] worker_plaintext,
    output logic                          busy,
    output logic                          found,
    output logic                          not_found,
    output logic                          timed_out,
    output logic [HASH_W-1:0]             result_plaintext,
    output logic [LANE_IDX_W-1:0]         result_lane,
    output logic [CNT_W-1:0]              cycle_count
);

    state_t                  state_reg;
    state_t                  state_next;
    logic [CNT_W-1:0]        load_cnt_reg;
    logic [CNT_W-1:0]        cycle_count_reg;
    logic [CNT_W-1:0]        cycle_count_inc;
    logic [HASH_W-1:0]       hash_reg;
    logic [INC_W-1:0]        increment_reg;
    logic [CHAR_W-1:0]       start_pos_reg [NUM_WORKERS];
    logic [HASH_W-1:0]       result_plaintext_reg;
    logic [LANE_IDX_W-1:0]   result_lane_reg;

    logic                    start_accept;
    logic                    clear_accept;
    logic                    in_run;
    logic                    load_done;
    logic                    run_exhausted;
    logic                    arb_any_hit;
    logic [LANE_IDX_W-1:0]   arb_lane;
    logic [HASH_W-1:0]       arb_plaintext;

    md5_hit_arbiter #(
        .NUM_WORKERS (NUM_WORKERS)
    ) u_hit_arbiter (
        .hit          (worker_hit),
        .plaintext_in (worker_plaintext),
        .any_hit      (arb_any_hit),
        .lane         (arb_lane),
        .plaintext    (arb_plaintext)
    );

    // start beats clear when both arrive in a terminal state.
    assign start_accept    = start && accepts_start(state_reg);
    assign clear_accept    = clear && !start && is_terminal(state_reg);
    assign in_run          = (state_reg == ST_RUN);
    assign load_done       = (load_cnt_reg == CNT_W'(RESET_CYCLES - 1));
    assign cycle_count_inc = (cycle_count_reg == '1) ? cycle_count_reg : cycle_count_reg + 1'b1;
    // Lanes need one cycle out of reset before their busy flag means anything;
    // cycle_count is still zero during that first RUN cycle.
    assign run_exhausted   = (cycle_count_reg != '0) && (worker_busy == '0);

`ifdef DISPATCH_TIMEOUT_EN
    logic timeout_hit;
    assign timeout_hit = (cycle_count_inc >= TIMEOUT_CYCLES);
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state decode; a hit outranks both timeout and exhaustion.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start) state_next = ST_LOAD;
            end
            ST_LOAD: begin
                if (load_done) state_next = ST_RUN;
            end
            ST_RUN: begin
                if (arb_any_hit) state_next = ST_FOUND;
`ifdef DISPATCH_TIMEOUT_EN
                else if (timeout_hit) state_next = ST_TIMEOUT;
`endif
                else if (run_exhausted) state_next = ST_NOT_FOUND;
            end
`ifdef DISPATCH_TIMEOUT_EN
            ST_FOUND, ST_NOT_FOUND, ST_TIMEOUT: begin
`else
            ST_FOUND, ST_NOT_FOUND: begin
`endif
                if (start)      state_next = ST_LOAD;
                else if (clear) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Status and lane-reset outputs, decoded from registered state only.
    always_comb begin
        worker_reset = !in_run;
        busy         = (state_reg == ST_LOAD) || in_run;
        found        = (state_reg == ST_FOUND);
        not_found    = (state_reg == ST_NOT_FOUND);
`ifdef DISPATCH_TIMEOUT_EN
        timed_out    = (state_reg == ST_TIMEOUT);
`else
        timed_out    = 1'b0;
`endif
    end

    // Job capture, LOAD hold-off counter, RUN cycle counter and result capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            hash_reg             <= '0;
            increment_reg        <= '0;
            load_cnt_reg         <= '0;
            cycle_count_reg      <= '0;
            result_plaintext_reg <= '0;
            result_lane_reg      <= '0;
        end else if (start_accept) begin
            hash_reg             <= target_hash_in;
            increment_reg        <= INC_W'(NUM_WORKERS);
            load_cnt_reg         <= '0;
            cycle_count_reg      <= '0;
            result_plaintext_reg <= '0;
            result_lane_reg      <= '0;
        end else begin
            if (state_reg == ST_LOAD) begin
                load_cnt_reg <= load_cnt_reg + 1'b1;
            end
            if (in_run) begin
                cycle_count_reg <= cycle_count_inc;
                if (arb_any_hit) begin
                    result_plaintext_reg <= arb_plaintext;
                    result_lane_reg      <= arb_lane;
                end
            end
            if (clear_accept) begin
                result_plaintext_reg <= '0;
                result_lane_reg      <= '0;
            end
        end
    end

    // Per-lane start character (8-bit wrap) and shared stride fan-out.
    for (genvar gi = 0; gi < NUM_WORKERS; gi++) begin : g_lane
        // Lane start position, captured alongside the job.
        always_ff @(posedge clk) begin
            if (reset) begin
                start_pos_reg[gi] <= '0;
            end else if (start_accept) begin
                start_pos_reg[gi] <= charset_start + CHAR_W'(gi);
            end
        end
        assign worker_start_pos[gi*CHAR_W +: CHAR_W] = start_pos_reg[gi];
        assign worker_increment[gi*INC_W +: INC_W]   = increment_reg;
    end

    assign worker_target_hash = hash_reg;
    assign result_plaintext   = result_plaintext_reg;
    assign result_lane        = result_lane_reg;
    assign cycle_count        = cycle_count_reg;

endmodule
